// File: rtl/s27_lockstep_pkg.sv
// s27_lockstep shared types and constants.
// FSM state encoding, per-channel stimulus width, delay limit.
package s27_lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int G_W     = 4;
  localparam int DLY_MAX = 7;
  localparam int WARM_W  = 3;

endpackage

// File: rtl/s27_core.sv
// One s27 benchmark core: three state flops, G17 output.
// Ports: CK, RN (async low), en (state load), g[3:0], g17.
module s27_core
  import s27_lockstep_pkg::*;
(
  input  logic           CK,
  input  logic           RN,
  input  logic           en,
  input  logic [G_W-1:0] g,
  output logic           g17
);

  logic g5, g6, g7;
  logic g8, g9, g10, g11, g12;
  logic g13, g14, g15, g16;

  always_comb begin
    g14 = ~g[0];
    g8  = g14 & g6;
    g12 = ~(g[1] | g7);
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = ~(g15 & g16);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g[2] | g12);
    g17 = ~g11;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      g5 <= 1'b0;
      g6 <= 1'b0;
      g7 <= 1'b0;
    end else if (en) begin
      g5 <= g10;
      g6 <= g11;
      g7 <= g13;
    end
  end

endmodule

// File: rtl/s27_lockstep.sv
// N_CH send/recv s27 pairs with delayed recv stimulus and a lockstep
// checker: ports CK, RN, en, g_in, inj, clr -> g17s, mismatch, err_cnt, fault, state.
module s27_lockstep
  import s27_lockstep_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DLY   = 2,
  parameter int CNT_W = 8
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  en,
  input  logic [G_W*N_CH-1:0]   g_in,
  input  logic [N_CH-1:0]       inj,
  input  logic                  clr,
  output logic [N_CH-1:0]       send_g17,
  output logic [N_CH-1:0]       recv_g17,
  output logic [N_CH-1:0]       mismatch,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  fault,
  output logic [1:0]            state
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(DLY);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  logic [G_W*N_CH-1:0] recv_g;
  logic [N_CH-1:0]     send_dly;
  logic [N_CH-1:0]     cmp;
  logic                qual;
  logic                hit;
  state_t              st, st_n;
  logic [WARM_W-1:0]   warm, warm_n;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    s27_core u_send (
      .CK  (CK),
      .RN  (RN),
      .en  (en),
      .g   (g_in[G_W*c +: G_W]),
      .g17 (send_g17[c])
    );
    s27_core u_recv (
      .CK  (CK),
      .RN  (RN),
      .en  (en),
      .g   (recv_g[G_W*c +: G_W]),
      .g17 (recv_g17[c])
    );
  end

  // Recv stimulus and send G17 share one shift discipline so the
  // two sides stay aligned across en stalls.
  if (DLY == 0) begin : g_nodly
    assign recv_g   = g_in;
    assign send_dly = send_g17;
  end else begin : g_dly
    logic [G_W*N_CH-1:0] g_pipe [DLY];
    logic [N_CH-1:0]     s_pipe [DLY];

    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        for (int i = 0; i < DLY; i++) begin
          g_pipe[i] <= '0;
          s_pipe[i] <= '0;
        end
      end else if (en) begin
        g_pipe[0] <= g_in;
        s_pipe[0] <= send_g17;
        for (int i = 1; i < DLY; i++) begin
          g_pipe[i] <= g_pipe[i-1];
          s_pipe[i] <= s_pipe[i-1];
        end
      end
    end

    assign recv_g   = g_pipe[DLY-1];
    assign send_dly = s_pipe[DLY-1];
  end

  assign cmp  = send_dly ^ (recv_g17 ^ inj);
  assign qual = en & ((st == RUN) | (st == FAULT));
  assign hit  = qual & (|cmp);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      mismatch <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      mismatch <= '0;
      err_cnt  <= '0;
    end else begin
      mismatch <= qual ? cmp : '0;
      if (hit && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    st_n   = st;
    warm_n = warm;
    unique case (st)
      IDLE: begin
        if (en) begin
          if (DLY == 0) begin
            st_n = RUN;
          end else begin
            st_n   = WARM;
            warm_n = WARM_INIT;
          end
        end
      end
      WARM: begin
        if (!en) begin
          st_n = IDLE;
        end else begin
          warm_n = warm - WARM_ONE;
          if (warm <= WARM_ONE)
            st_n = RUN;
        end
      end
      RUN: begin
        if (!en)
          st_n = IDLE;
        else if (hit && !clr)
          st_n = FAULT;
      end
      FAULT: begin
        if (clr)
          st_n = en ? RUN : IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      st   <= IDLE;
      warm <= '0;
    end else begin
      st   <= st_n;
      warm <= warm_n;
    end
  end

  assign fault = (st == FAULT);
  assign state = st;

endmodule

// File: tb/tb_s27_lockstep.sv
// Randomized bench for s27_lockstep against a queue-based model.
// Directed phases: reset, warm-up, injection, saturation, clr, stall.
module tb_s27_lockstep;

  localparam int N    = 4;
  localparam int D    = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CK  = 1'b0;
  logic          RN  = 1'b0;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [4*N-1:0] g_in = '0;
  logic [N-1:0]  inj = '0;
  logic [N-1:0]  send_g17, recv_g17, mismatch;
  logic [CW-1:0] err_cnt;
  logic          fault;
  logic [1:0]    state;

  s27_lockstep #(.N_CH(N), .DLY(D), .CNT_W(CW)) dut (
    .CK       (CK),
    .RN       (RN),
    .en       (en),
    .g_in     (g_in),
    .inj      (inj),
    .clr      (clr),
    .send_g17 (send_g17),
    .recv_g17 (recv_g17),
    .mismatch (mismatch),
    .err_cnt  (err_cnt),
    .fault    (fault),
    .state    (state)
  );

  always #5 CK = ~CK;

  int n_chk;
  int n_fail;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: core states, delay queues, and a 0..3 mode number.
  bit [2:0]     ss [N];
  bit [2:0]     rs [N];
  bit [4*N-1:0] qg [$];
  bit [N-1:0]   qs [$];
  int           mst;
  int           warm;
  int           cnt;
  bit [N-1:0]   mm;
  bit [N-1:0]   e_send, e_recv, e_cmp;

  // s = {G7,G6,G5}; returns {G7',G6',G5',G17}
  function automatic bit [3:0] core(bit [2:0] s, bit [3:0] g);
    bit g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = !g[0];
    g8  = g14 & s[1];
    g12 = !(g[1] | s[2]);
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = !(g15 & g16);
    g11 = !(s[0] | g9);
    g10 = !(g14 | g11);
    g13 = !(g[2] | g12);
    return {g13, g11, g10, !g11};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      ss[c] = '0;
      rs[c] = '0;
    end
    qg.delete();
    qs.delete();
    for (int i = 0; i < D; i++) begin
      qg.push_back('0);
      qs.push_back('0);
    end
    mst  = 0;
    warm = 0;
    cnt  = 0;
    mm   = '0;
  endfunction

  function automatic void eval();
    bit [3:0] r;
    for (int c = 0; c < N; c++) begin
      r = core(ss[c], g_in[4*c +: 4]);
      e_send[c] = r[0];
      r = core(rs[c], qg[0][4*c +: 4]);
      e_recv[c] = r[0];
    end
    e_cmp = qs[0] ^ e_recv ^ inj;
  endfunction

  function automatic void model_edge();
    bit       q, hit;
    bit [3:0] r;
    if (!RN) begin
      model_reset();
      return;
    end
    eval();
    q   = en && (mst >= 2);
    hit = q && (e_cmp != 0);
    if (clr) begin
      mm  = '0;
      cnt = 0;
    end else begin
      mm = q ? e_cmp : '0;
      if (hit && cnt < CMAX) cnt++;
    end
    case (mst)
      0: if (en) begin
           mst  = 1;
           warm = D;
         end
      1: if (!en) mst = 0;
         else begin
           warm--;
           if (warm == 0) mst = 2;
         end
      2: if (!en) mst = 0;
         else if (hit && !clr) mst = 3;
      default: if (clr) mst = en ? 2 : 0;
    endcase
    if (en) begin
      for (int c = 0; c < N; c++) begin
        r = core(ss[c], g_in[4*c +: 4]);
        ss[c] = r[3:1];
        r = core(rs[c], qg[0][4*c +: 4]);
        rs[c] = r[3:1];
      end
      qg.push_back(g_in);
      void'(qg.pop_front());
      qs.push_back(e_send);
      void'(qs.pop_front());
    end
  endfunction

  task automatic check_all(input string ph);
    eval();
    check({ph, ".send"}, 32'(send_g17), 32'(e_send));
    check({ph, ".recv"}, 32'(recv_g17), 32'(e_recv));
    check({ph, ".mm"}, 32'(mismatch), 32'(mm));
    check({ph, ".cnt"}, 32'(err_cnt), 32'(cnt));
    check({ph, ".state"}, 32'(state), 32'(mst));
    check({ph, ".fault"}, 32'(fault), 32'(mst == 3));
  endtask

  task automatic tick(input string ph);
    #1;
    check_all(ph);
    @(posedge CK);
    model_edge();
    @(negedge CK);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();

    @(negedge CK);
    check_all("reset");
    check("rst_send", 32'(send_g17), 32'hF);
    check("rst_recv", 32'(recv_g17), 32'hF);
    check("rst_state", 32'(state), 32'd0);
    tick("reset");

    RN = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      g_in = 16'($urandom);
      tick("warm_run");
      if (i < 3)
        check("warm_t", 32'(state), (i < 2) ? 32'd1 : 32'd2);
    end
    check("clean_cnt", 32'(err_cnt), 32'd0);
    check("clean_mm", 32'(mismatch), 32'd0);

    g_in = 16'($urandom);
    inj  = 4'b0010;
    tick("inj");
    check("inj_mm", 32'(mismatch), 32'h2);
    check("inj_cnt", 32'(err_cnt), 32'd1);
    check("inj_state", 32'(state), 32'd3);
    check("inj_fault", 32'(fault), 32'd1);
    inj = '0;
    tick("inj_after");
    check("inj2_mm", 32'(mismatch), 32'd0);
    check("inj2_state", 32'(state), 32'd3);

    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
    check("clr_state", 32'(state), 32'd2);
    check("clr_cnt", 32'(err_cnt), 32'd0);

    inj = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      g_in = 16'($urandom);
      tick("sat");
    end
    inj = '0;
    check("sat_cnt", 32'(err_cnt), 32'd15);
    check("sat_state", 32'(state), 32'd3);
    clr = 1'b1;
    tick("sat_clr");
    clr = 1'b0;
    check("satclr_cnt", 32'(err_cnt), 32'd0);
    check("satclr_state", 32'(state), 32'd2);
    check("satclr_mm", 32'(mismatch), 32'd0);

    clr = 1'b1;
    inj = 4'hF;
    tick("collide");
    clr = 1'b0;
    inj = '0;
    check("col_cnt", 32'(err_cnt), 32'd0);
    check("col_state", 32'(state), 32'd2);
    check("col_mm", 32'(mismatch), 32'd0);

    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      g_in = 16'($urandom);
      tick("stall");
    end
    check("stall_state", 32'(state), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g_in = 16'($urandom);
      inj  = 4'($urandom);
      tick("rewarm");
    end
    inj = '0;
    check("rewarm_state", 32'(state), 32'd2);
    check("rewarm_cnt", 32'(err_cnt), 32'd0);
    check("rewarm_mm", 32'(mismatch), 32'd0);
    for (int i = 0; i < 20; i++) begin
      g_in = 16'($urandom);
      tick("run2");
    end

    for (int i = 0; i < 400; i++) begin
      g_in = 16'($urandom);
      en   = ($urandom % 8) != 0;
      inj  = (($urandom % 16) == 0) ? 4'($urandom) : 4'h0;
      clr  = ($urandom % 24) == 0;
      tick("rand");
    end

    en  = 1'b1;
    inj = '0;
    clr = 1'b1;
    tick("pre_rst");
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      g_in = 16'($urandom);
      tick("pre_rst");
    end
    check("pre_rst_state", 32'(state), 32'd2);

    RN = 1'b0;
    #1;
    model_reset();
    check("arst_state", 32'(state), 32'd0);
    check("arst_cnt", 32'(err_cnt), 32'd0);
    check("arst_mm", 32'(mismatch), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    tick("in_rst");
    RN = 1'b1;
    for (int i = 0; i < 30; i++) begin
      g_in = 16'($urandom);
      tick("post_rst");
      if (i < 3)
        check("rwarm_t", 32'(state), (i < 2) ? 32'd1 : 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
